// File: rtl/snn_pkt_pkg.sv
// Packet layout, FSM states and shared constants for the SNN conv neuron.
package snn_pkt_pkg;

  typedef struct packed {
    logic [4:0]  ptype;
    logic [2:0]  id;
    logic [23:0] payload;
  } pkt_t;

  localparam logic [4:0] PKT_FILT = 5'b01000;
  localparam logic [4:0] PKT_IFM  = 5'b00000;
  localparam logic [4:0] PKT_OFM  = 5'b10000;
  localparam logic [2:0] MP_ID    = 3'd4;
  localparam int         ACC_W    = 12;

  typedef enum logic [2:0] {
    ROW1,
    ROW2,
    ROW3,
    MP,
    FIRE
  } state_e;

  function automatic logic [2:0] row_id(state_e s);
    logic [2:0] r;
    r = 3'd1;
    unique case (1'b1)
      (s == ROW2): r = 3'd2;
      (s == ROW3): r = 3'd3;
      default:     r = 3'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snn_conv_neuron_row_mac.sv
// Combinational 3-tap MAC: WIDTH-bit weights gated by 1-bit spikes.
module snn_row_mac #(
  parameter int WIDTH = 8
) (
  input  logic [2:0][WIDTH-1:0] w_i,
  input  logic [2:0]            s_i,
  output logic [WIDTH+1:0]      sum_o
);

  logic [WIDTH+1:0] t0, t1, t2;

  assign t0    = s_i[0] ? {2'b00, w_i[0]} : '0;
  assign t1    = s_i[1] ? {2'b00, w_i[1]} : '0;
  assign t2    = s_i[2] ? {2'b00, w_i[2]} : '0;
  assign sum_o = t0 + t1 + t2;

endmodule

// File: rtl/snn_conv_neuron.sv
// Spiking conv neuron: 3x3 filter regfile, row accumulation,
// optional old-membrane add, threshold/fire, one ofmap packet per position.
module snn_conv_neuron
  import snn_pkt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OFX    = 3,
  parameter int OFY    = 3,
  parameter int THRESH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        first_ts,
  output logic        pkt_err
);

  localparam int NPOS = OFX * OFY;
  localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam logic [ACC_W-1:0] TH   = ACC_W'(THRESH);
  localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << WIDTH) - 1);

  state_e                 state_q;
  logic [ACC_W-1:0]       acc_q;
  logic [PW-1:0]          pos_q;
  logic [2:0][WIDTH-1:0]  w_q [3];
  logic [31:0]            out_data_q;
  logic                   out_valid_q;
  logic                   first_ts_q;
  logic                   pkt_err_q;

  pkt_t                   pkt;
  logic                   accept;
  logic                   is_ifm;
  logic                   is_filt;
  logic                   filt_ok;
  logic [1:0]             ridx;
  logic [2:0]             spikes;
  logic [2:0][WIDTH-1:0]  mac_w;
  logic [WIDTH+1:0]       mac_sum;
  logic                   fire;
  logic [ACC_W-1:0]       pot_sub;
  logic [7:0]             pot8;

  assign pkt      = pkt_t'(in_data);
  assign in_ready = !out_valid_q && (state_q != FIRE);
  assign accept   = in_valid && in_ready;
  assign is_ifm   = (pkt.ptype == PKT_IFM);
  assign is_filt  = (pkt.ptype == PKT_FILT);
  assign filt_ok  = is_filt && (pkt.id >= 3'd1) && (pkt.id <= 3'd3);
  assign ridx     = pkt.id[1:0] - 2'd1;
  assign spikes   = {pkt.payload[16], pkt.payload[8], pkt.payload[0]};

  always_comb begin
    mac_w = w_q[0];
    unique case (1'b1)
      (state_q == ROW2): mac_w = w_q[1];
      (state_q == ROW3): mac_w = w_q[2];
      default:           mac_w = w_q[0];
    endcase
  end

  snn_row_mac #(.WIDTH(WIDTH)) u_mac (
    .w_i   (mac_w),
    .s_i   (spikes),
    .sum_o (mac_sum)
  );

  // Subtract-on-fire, then clamp into the WIDTH-bit membrane range.
  assign fire    = (acc_q >= TH);
  assign pot_sub = fire ? (acc_q - TH) : acc_q;
  assign pot8    = (pot_sub > MAXV) ? MAXV[7:0] : pot_sub[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ROW1;
      acc_q       <= '0;
      pos_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      first_ts_q  <= 1'b1;
      pkt_err_q   <= 1'b0;
      for (int r = 0; r < 3; r++) w_q[r] <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        if (pos_q == PW'(NPOS - 1)) begin
          pos_q      <= '0;
          first_ts_q <= 1'b0;
        end else begin
          pos_q <= pos_q + 1'b1;
        end
      end
      unique case (state_q)
        ROW1, ROW2, ROW3: begin
          if (accept) begin
            if (is_ifm && pkt.id == row_id(state_q)) begin
              acc_q <= acc_q + ACC_W'(mac_sum);
              unique case (state_q)
                ROW1:    state_q <= ROW2;
                ROW2:    state_q <= ROW3;
                default: state_q <= first_ts_q ? FIRE : MP;
              endcase
            end else if (filt_ok) begin
              w_q[ridx] <= {WIDTH'(pkt.payload[23:16]),
                            WIDTH'(pkt.payload[15:8]),
                            WIDTH'(pkt.payload[7:0])};
            end else begin
              pkt_err_q <= 1'b1;
            end
          end
        end
        MP: begin
          if (accept) begin
            if (is_ifm && pkt.id == MP_ID) begin
              acc_q   <= acc_q + ACC_W'(pkt.payload[7:0]);
              state_q <= FIRE;
            end else begin
              pkt_err_q <= 1'b1;
            end
          end
        end
        FIRE: begin
          out_data_q  <= {PKT_OFM, 3'b000, 15'b0, fire, pot8};
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          state_q     <= ROW1;
        end
        default: state_q <= ROW1;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign first_ts  = first_ts_q;
  assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_snn_conv_neuron.sv
// Directed bench for snn_conv_neuron with hand-computed ofmap packets.
module tb_snn_conv_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        first_ts;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;

  snn_conv_neuron #(.WIDTH(8), .OFX(3), .OFY(3), .THRESH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .first_ts  (first_ts),
    .pkt_err   (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] filt(input logic [2:0] id, input logic [7:0] c2,
                                       input logic [7:0] c1, input logic [7:0] c0);
    return {5'b01000, id, c2, c1, c0};
  endfunction

  function automatic logic [31:0] ifm(input logic [2:0] id, input logic [2:0] s);
    return {5'b00000, id, 7'b0, s[2], 7'b0, s[1], 7'b0, s[0]};
  endfunction

  function automatic logic [31:0] mp(input logic [7:0] v);
    return {5'b00000, 3'd4, 16'b0, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic load_filter(input logic [7:0] base);
    send(filt(3'd1, base + 8'd2, base + 8'd1, base));
    send(filt(3'd2, base + 8'd5, base + 8'd4, base + 8'd3));
    send(filt(3'd3, base + 8'd8, base + 8'd7, base + 8'd6));
  endtask

  task automatic rows(input logic [2:0] s1, input logic [2:0] s2,
                      input logic [2:0] s3);
    send(ifm(3'd1, s1));
    send(ifm(3'd2, s2));
    send(ifm(3'd3, s3));
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_first_ts", {31'b0, first_ts}, 32'd1);
    chk("rst_pkt_err", {31'b0, pkt_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Filter rows [1,2,3],[4,5,6],[7,8,9]; all spikes -> 45
    load_filter(8'd1);
    rows(3'b111, 3'b111, 3'b111);
    chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    get_out("t1_sum45", 32'h8000_002D);
    chk("t1_first_ts", {31'b0, first_ts}, 32'd1);

    // Sparse spikes: col0 of row1 (1) + col1 of row2 (5) + col2 of row3 (9)
    rows(3'b001, 3'b010, 3'b100);
    get_out("t2_sparse15", 32'h8000_000F);
    for (int p = 2; p < 9; p++) begin
      rows(3'b111, 3'b111, 3'b111);
      if (p == 8) chk("t2_first_ts_before_wrap", {31'b0, first_ts}, 32'd1);
      get_out("t2_pos45", 32'h8000_002D);
    end
    chk("t2_first_ts_cleared", {31'b0, first_ts}, 32'd0);

    // Second timestep: 45 + old 30 = 75 -> fire, 11
    rows(3'b111, 3'b111, 3'b111);
    tick();
    chk("t2_wait_mp", {31'b0, out_valid}, 32'd0);
    send(mp(8'd30));
    get_out("t2_mp75", 32'h8000_010B);

    // All 255 weights, all spikes, old 255 -> 2550 -> saturate
    send(filt(3'd1, 8'd255, 8'd255, 8'd255));
    send(filt(3'd2, 8'd255, 8'd255, 8'd255));
    send(filt(3'd3, 8'd255, 8'd255, 8'd255));
    rows(3'b111, 3'b111, 3'b111);
    send(mp(8'd255));
    get_out("t3_saturate", 32'h8000_01FF);
    chk("t3_no_err", {31'b0, pkt_err}, 32'd0);

    // Out-of-order row id: dropped, sticky error; 255 + 10 = 265 -> 201
    send(ifm(3'd2, 3'b111));
    chk("t4_pkt_err", {31'b0, pkt_err}, 32'd1);
    rows(3'b001, 3'b000, 3'b000);
    send(mp(8'd10));
    get_out("t4_after_drop", 32'h8000_01C9);
    chk("t4_err_sticky", {31'b0, pkt_err}, 32'd1);

    // Exactly at threshold with output back-pressure
    rows(3'b000, 3'b000, 3'b000);
    send(mp(8'd64));
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("t5_hold_data", out_data, 32'h8000_0100);
      chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_one_xfer", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t5_still_idle", {31'b0, out_valid}, 32'd0);
    chk("t5_in_ready_back", {31'b0, in_ready}, 32'd1);

    // Just below threshold
    rows(3'b000, 3'b000, 3'b000);
    send(mp(8'd63));
    get_out("t5_below63", 32'h8000_003F);

    // Reset mid-position discards partial sum and weights
    send(ifm(3'd1, 3'b111));
    send(ifm(3'd2, 3'b111));
    #2 rst = 1'b1;
    #1;
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_first_ts", {31'b0, first_ts}, 32'd1);
    chk("t6_pkt_err", {31'b0, pkt_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    load_filter(8'd1);
    rows(3'b111, 3'b111, 3'b111);
    get_out("t6_fresh45", 32'h8000_002D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
